// File: rtl/spi_mem_arbiter_pkg.sv
// Shared definitions for the SPI/host DataMemory arbiter: FSM state
// encoding, requester port indices and the statistics counter helper.
package spi_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COMPLETE = 2'd2
  } arb_state_e;

  localparam logic PORT_SPI  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  // Wide enough for the largest legal MAX_WAIT (15).
  localparam int WAIT_W = 4;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  // Saturating +1 for the 16-bit grant statistics.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == STAT_MAX) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/spi_mem_arbiter_wait_counter.sv
// Bounded-wait counter for the host port: counts consecutive host losses,
// saturates at MAX_WAIT and reports saturation so the host is forced to win.
module arb_wait_counter
  import spi_mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic sat_o
);

  localparam logic [WAIT_W-1:0] MAX_C = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  // Next count: clear wins over increment; increment stops at MAX_WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {WAIT_W{1'b0}};
    end else if (inc_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {WAIT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == MAX_C);

endmodule

// File: rtl/spi_mem_arbiter.sv
// Two-port arbiter in front of the single-port 128x8 DataMemory.
// Port 0 (SPI sequencer) has fixed priority; port 1 (host/debug) is
// guaranteed a grant after MAX_WAIT consecutive losses.
// Optional grant statistics are built only when ARB_STATS_EN is defined.
module spi_mem_arbiter
  import spi_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
);

  arb_state_e        state_q;
  logic              winner_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic [DATA_W-1:0] rdata_q;

  logic any_req_s;
  logic win1_s;
  logic grant_s;
  logic wait_sat_s;
  logic wait_inc_s;
  logic wait_clr_s;

  // Arbitration decision: host wins when alone or when its wait has saturated.
  always_comb begin
    any_req_s = req0 | req1;
    win1_s    = req1 & (~req0 | wait_sat_s);
    grant_s   = (state_q == ST_IDLE) & any_req_s;
  end

  assign wait_inc_s = grant_s & req1 & ~win1_s;
  assign wait_clr_s = grant_s & win1_s;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .clr_i (wait_clr_s),
    .inc_i (wait_inc_s),
    .sat_o (wait_sat_s)
  );

  // Access FSM: latch the winner in IDLE, drive memory in ISSUE, pulse ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      winner_q   <= PORT_SPI;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= {ADDR_W{1'b0}};
      mem_din_q  <= {DATA_W{1'b0}};
      rdata_q    <= {DATA_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req_s) begin
            winner_q   <= win1_s ? PORT_HOST : PORT_SPI;
            mem_addr_q <= win1_s ? addr1 : addr0;
            mem_we_q   <= win1_s ? we1 : we0;
            mem_din_q  <= win1_s ? wdata1 : wdata0;
            state_q    <= ST_ISSUE;
          end else begin
            state_q    <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // A write commits on this edge; rdata keeps its value after writes.
          if (!mem_we_q) begin
            rdata_q <= mem_dout;
          end else begin
            rdata_q <= rdata_q;
          end
          mem_we_q <= 1'b0;
          ack0_q   <= (winner_q == PORT_SPI);
          ack1_q   <= (winner_q == PORT_HOST);
          state_q  <= ST_COMPLETE;
        end
        ST_COMPLETE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          ack0_q   <= 1'b0;
          ack1_q   <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign rdata    = rdata_q;

`ifdef ARB_STATS_EN
  logic [15:0] grant_cnt0_q;
  logic [15:0] grant_cnt1_q;

  // Saturating per-port grant counters, bumped on every IDLE grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0_q <= 16'd0;
      grant_cnt1_q <= 16'd0;
    end else if (grant_s) begin
      if (win1_s) begin
        grant_cnt1_q <= sat_inc16(grant_cnt1_q);
      end else begin
        grant_cnt0_q <= sat_inc16(grant_cnt0_q);
      end
    end else begin
      grant_cnt0_q <= grant_cnt0_q;
      grant_cnt1_q <= grant_cnt1_q;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`else
  assign grant_cnt0 = 16'd0;
  assign grant_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed self-checking bench for spi_mem_arbiter with a behavioural
// 128x8 DataMemory (combinational read, write on the clock edge).
module tb_spi_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [6:0] addr0 = 7'd0, addr1 = 7'd0;
  logic [7:0] wdata0 = 8'd0, wdata1 = 8'd0;
  logic       ack0, ack1, mem_we;
  logic [7:0] rdata, mem_din, mem_dout;
  logic [6:0] mem_addr;
  logic [15:0] grant_cnt0, grant_cnt1;

  logic [7:0] mem [0:127];
  logic       pl_en = 1'b0;
  logic [6:0] pl_addr = 7'd0;
  logic [7:0] pl_data = 8'd0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  spi_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // One complete access from an idle arbiter; lat = cycles to ack (-1 on timeout).
  task automatic access(input logic port, input logic we, input logic [6:0] a,
                        input logic [7:0] d, output int lat, output int we_cyc,
                        output logic [6:0] we_addr, output logic ack_after);
    logic got;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    lat = 0; we_cyc = 0; we_addr = 7'd0; got = 1'b0;
    while (!got && lat < 10) begin
      tick();
      lat++;
      if (mem_we) begin we_cyc++; we_addr = mem_addr; end
      got = port ? ack1 : ack0;
    end
    req0 = 1'b0; req1 = 1'b0;
    if (!got) lat = -1;
    tick();
    ack_after = port ? ack1 : ack0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b expected 0", ack0); end
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1: got %b expected 0", ack1); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 7'h00) begin errors++; $display("FAIL reset_mem_addr: got %h expected 00", mem_addr); end
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_din: got %h expected 00", mem_din); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    checks++; if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", grant_cnt0, grant_cnt1); end
  endtask

  task automatic test_single_read();
    int lat, wc; logic [6:0] wa; logic aa;
    preload(7'h05, 8'hA5);
    access(1'b1, 1'b0, 7'h05, 8'h00, lat, wc, wa, aa);
    checks++; if (lat !== 2) begin errors++; $display("FAIL read_latency: got %0d expected 2", lat); end
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL read_rdata: got %h expected a5", rdata); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL read_mem_we: got %0d write cycles expected 0", wc); end
    checks++; if (aa !== 1'b0) begin errors++; $display("FAIL read_ack_pulse: ack still %b expected 0", aa); end
  endtask

  task automatic test_write_read();
    int lat, wc; logic [6:0] wa; logic aa;
    access(1'b0, 1'b1, 7'h7F, 8'h3C, lat, wc, wa, aa);
    checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency: got %0d expected 2", lat); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL write_we_cycles: got %0d expected 1", wc); end
    checks++; if (wa !== 7'h7F) begin errors++; $display("FAIL write_addr: got %h expected 7f", wa); end
    checks++; if (mem[7'h7F] !== 8'h3C) begin errors++; $display("FAIL write_mem: got %h expected 3c", mem[7'h7F]); end
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL write_rdata_held: got %h expected a5", rdata); end
    checks++; if (aa !== 1'b0) begin errors++; $display("FAIL write_ack_pulse: ack still %b expected 0", aa); end
    access(1'b0, 1'b0, 7'h7F, 8'h00, lat, wc, wa, aa);
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL readback_rdata: got %h expected 3c", rdata); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL readback_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_priority();
    int cyc = 0, t0 = -1, t1 = -1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h05;
    req1 = 1'b1; we1 = 1'b0; addr1 = 7'h7F;
    while ((t0 < 0 || t1 < 0) && cyc < 15) begin
      tick();
      cyc++;
      if (ack0 && t0 < 0) begin t0 = cyc; req0 = 1'b0; end
      if (ack1 && t1 < 0) begin t1 = cyc; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    checks++; if (t0 !== 2) begin errors++; $display("FAIL priority_ack0_cycle: got %0d expected 2", t0); end
    checks++; if (t1 !== 5) begin errors++; $display("FAIL priority_ack1_cycle: got %0d expected 5", t1); end
  endtask

  task automatic test_starvation();
    logic [9:0] seq = 10'd0;
    int n = 0, cyc = 0, last = 0, first1 = -1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 7'h02;
    while (n < 10 && cyc < 60) begin
      tick();
      cyc++;
      if (ack0 || ack1) begin
        seq[n] = ack1;
        if (ack1 && first1 < 0) first1 = n;
        n++;
        last = cyc;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    checks++; if (first1 !== 4) begin errors++; $display("FAIL starve_port0_wins: got %0d expected 4", first1); end
    checks++; if (seq !== 10'b1000010000) begin errors++; $display("FAIL starve_sequence: got %b expected 1000010000", seq); end
    checks++; if (last !== 29) begin errors++; $display("FAIL starve_spacing: tenth ack at %0d expected 29", last); end
  endtask

  task automatic test_reset_mid_write();
    int lat, wc; logic [6:0] wa; logic aa;
    preload(7'h10, 8'h00);
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h10; wdata0 = 8'hFF;
    tick();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL midrst_issue_we: got %b expected 1", mem_we); end
    reset = 1'b1; req0 = 1'b0;
    tick();
    reset = 1'b0;
    checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin errors++; $display("FAIL midrst_ack: got %b%b expected 00", ack0, ack1); end
    checks++; if (mem[7'h10] !== 8'hFF) begin errors++; $display("FAIL midrst_commit: got %h expected ff", mem[7'h10]); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 7'h00 || mem_din !== 8'h00 || rdata !== 8'h00) begin
      errors++; $display("FAIL midrst_outputs: we=%b addr=%h din=%h rdata=%h expected 0/00/00/00", mem_we, mem_addr, mem_din, rdata);
    end
    tick();
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL midrst_late_ack: got %b expected 0", ack0); end
    access(1'b1, 1'b0, 7'h10, 8'h00, lat, wc, wa, aa);
    checks++; if (lat !== 2) begin errors++; $display("FAIL midrst_idle_latency: got %0d expected 2", lat); end
    checks++; if (rdata !== 8'hFF) begin errors++; $display("FAIL midrst_readback: got %h expected ff", rdata); end
  endtask

  task automatic test_stats();
    int lat, wc; logic [6:0] wa; logic aa;
    logic [15:0] exp0, exp1;
    do_reset();
    for (int i = 0; i < 3; i++) access(1'b0, 1'b0, 7'h05, 8'h00, lat, wc, wa, aa);
    for (int i = 0; i < 2; i++) access(1'b1, 1'b0, 7'h7F, 8'h00, lat, wc, wa, aa);
`ifdef ARB_STATS_EN
    exp0 = 16'd3; exp1 = 16'd2;
`else
    exp0 = 16'd0; exp1 = 16'd0;
`endif
    checks++; if (grant_cnt0 !== exp0) begin errors++; $display("FAIL stats_cnt0: got %0d expected %0d", grant_cnt0, exp0); end
    checks++; if (grant_cnt1 !== exp1) begin errors++; $display("FAIL stats_cnt1: got %0d expected %0d", grant_cnt1, exp1); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_priority();
    test_starvation();
    test_reset_mid_write();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
- Shares the single 128x8 DataMemory port between two requesters: port 0, the SPI slave sequencer, and port 1, a local host/debug port such as an LED scanner or self-test.
- Port 0 has fixed priority because SPI bit timing is hard.
- A bounded-wait counter guarantees that port 1 makes progress.
- Sits between the requesters and the DataMemory clk/addr/we/din/dout pins and replaces direct FSM-to-memory wiring.

Parameters:
- ADDR_W, 7, memory word-address width.
- DATA_W, 8, data width.
- MAX_WAIT, 4, number of consecutive port-1 losses before port 1 is forced to win. Legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 request; held until ack0
- we0  in  1  port 0 write enable (1 = write, 0 = read)
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- ack0  out  1  one-cycle completion pulse to port 0
- req1, we1, addr1, wdata1, ack1  same meaning for port 1
- rdata  out  DATA_W  read data; valid in the ack cycle, held until the next ack
- mem_addr  out  ADDR_W  DataMemory address
- mem_we  out  1  DataMemory write enable
- mem_din  out  DATA_W  DataMemory write data
- mem_dout  in  DATA_W  DataMemory read data; combinational from mem_addr
- grant_cnt0, grant_cnt1  out  16  grant statistics; see Optional Feature

Behaviour:
- Reset values:
  - state = IDLE.
  - ack0, ack1, mem_we = 0.
  - mem_addr, mem_din, rdata = 0.
  - wait counter = 0; statistics counters = 0.
- All outputs are registered.
- FSM has three states: IDLE, ISSUE, COMPLETE.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise choose the winner:
    - port 1 wins if req1 = 1 and (req0 = 0 or wait_cnt == MAX_WAIT);
    - else port 0 wins.
  - Latch the winner's addr, we and wdata into mem_addr, mem_we and mem_din; record the winner index; go to ISSUE.
- ISSUE:
  - The memory sees the stable address.
  - If mem_we = 1, the write commits at the end of this cycle.
  - At the end of the cycle: rdata <= mem_dout (read only), mem_we <= 0, ackN <= 1 for the winner, go to COMPLETE.
- COMPLETE:
  - ackN is high for exactly this cycle, then clears; go to IDLE.
- Latency: request seen in IDLE at cycle t means ack at cycle t+2. Minimum spacing between grants is 3 cycles.
- Handshake:
  - A requester holds req, we, addr and wdata stable from assertion until it samples ack = 1.
  - A requester must clear req on the clock edge where it samples ack, so the next IDLE does not see a stale request.
  - A req that drops before ack is ignored once latched; the access still completes and still acks.
- Wait counter:
  - Increments, saturating at MAX_WAIT, in each IDLE decision where req1 = 1 and port 0 wins.
  - Clears when port 1 is granted.
  - Holds otherwise.
- Simultaneous requests: port 0 wins unless the wait counter is saturated. Back-to-back port-0 streams therefore yield to port 1 every MAX_WAIT+1 grants.
- rdata is undefined-but-stable after a write ack: it keeps its previous value.
- Reset mid-operation:
  - If reset is sampled in ISSUE with mem_we = 1, the memory write still commits; the memory has no reset.
  - No ack is produced for that access.
  - The FSM returns to IDLE on that edge.
- Address is passed through unmodified; there is no wrap or translation.

Optional Feature:
- Macro: ARB_STATS_EN.
- With the macro:
  - grant_cnt0 and grant_cnt1 increment by 1 on each IDLE grant to the corresponding port.
  - Counters saturate at 16'hFFFF.
  - Counters clear on reset.
- Without the macro: both outputs are constant 0 and no counter flops are generated.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_COMPLETE = 2'd2;
  - port indices PORT_SPI = 1'b0, PORT_HOST = 1'b1.
- One natural sub-module: arb_wait_counter, a saturating counter with clear and increment inputs and a sat output, parameterised by MAX_WAIT.

Test Plan:
- Single read: after reset, preload mem[0x05] = 8'hA5; req1 read addr 0x05 → ack1 two cycles later with rdata = 8'hA5; mem_we stays 0.
- Write then read: req0 write addr 0x7F, data 8'h3C → mem_we high for exactly one cycle with mem_addr = 0x7F; a later req0 read of 0x7F → rdata = 8'h3C.
- Priority: req0 and req1 asserted in the same cycle → ack0 first; ack1 follows 3 cycles after ack0.
- Starvation: req0 re-requests continuously and req1 is held, MAX_WAIT = 4 → exactly 4 port-0 grants, then a port-1 grant; the wait counter returns to 0.
- Reset mid-write: assert reset during ISSUE of a write to 0x10 with 8'hFF → no ack; state is IDLE next cycle; mem[0x10] = 8'hFF; all outputs are at reset values.
- With ARB_STATS_EN: after 3 port-0 grants and 2 port-1 grants → grant_cnt0 = 3, grant_cnt1 = 2. Without the macro both read 0.
